// File: rtl/fir_tdm_sequencer.sv
// ---------------------------------------------------------------------------
// fir_tdm_sequencer
//
// Time-division-multiplexed FIR controller. One external 16x16 sign-magnitude
// multiplier is shared across all ORDER taps. Each accepted sample is followed
// by ORDER multiply-accumulate cycles and then an output hold state.
//
// Ports
//   clk_slow   : system clock, rising edge
//   rst        : synchronous, active-low reset
//   in_valid/in_ready/fir_in     : sample input handshake (sign-magnitude)
//   out_valid/out_ready/fir_out  : result output handshake (sign-magnitude)
//   coef_we/coef_addr/coef_data  : coefficient bank write port (IDLE only)
//   coef_err   : one-cycle pulse after a rejected coefficient write
//   flush      : clears the sample history (IDLE only)
//   mult_a/mult_b : operands to the shared multiplier (zero outside MAC)
//   mult_p     : combinational product, bit30 sign, [29:0] magnitude
//   busy       : high whenever the sequencer is not IDLE
// ---------------------------------------------------------------------------
module fir_tdm_sequencer #(
   parameter int ORDER = 30,
   parameter int AW    = 6,
   parameter int ACC_W = 36
) (
   input  logic          clk_slow,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [15:0]   fir_in,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [15:0]   fir_out,
   input  logic          coef_we,
   input  logic [AW-1:0] coef_addr,
   input  logic [15:0]   coef_data,
   output logic          coef_err,
   input  logic          flush,
   output logic [15:0]   mult_a,
   output logic [15:0]   mult_b,
   input  logic [30:0]   mult_p,
   output logic          busy
);

   localparam logic [AW-1:0] LAST_K   = AW'(ORDER - 1);
   // ORDER taken modulo 2^AW; modular index arithmetic stays correct even
   // when ORDER == 2^AW and this constant becomes 0.
   localparam logic [AW-1:0] ORDER_LO = AW'(ORDER);
   localparam logic [AW:0]   ORDER_X  = (AW+1)'(ORDER);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MAC  = 2'd1,
      ST_OUT  = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [15:0]      coef_q [ORDER];
   logic [15:0]      hist_q [ORDER];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    newest_q;
   logic [AW-1:0]    k_q;
   logic [ACC_W-1:0] acc_q;
   logic [15:0]      fir_out_q;
   logic             coef_err_q;

   logic             is_idle;
   logic             is_mac;
   logic             last_tap;
   logic             accept;
   logic             coef_ok;
   logic             hist_clr;
   logic [AW-1:0]    wr_idx;
   logic [AW-1:0]    wr_ptr_inc;
   logic [AW-1:0]    rd_idx;
   logic [ACC_W-1:0] prod_mag;
   logic [ACC_W-1:0] prod_s;
   logic [ACC_W-1:0] acc_sum;
   logic [ACC_W-16:0] abs_hi;
   logic             sat;
   logic [14:0]      res_mag;
   logic             res_neg;

   // ------------------------------------------------------------------------
   // Control decode
   // ------------------------------------------------------------------------
   assign is_idle  = (state_q == ST_IDLE);
   assign is_mac   = (state_q == ST_MAC);
   assign last_tap = (k_q == LAST_K);
   assign accept   = is_idle && in_valid;
   assign hist_clr = is_idle && flush;
   assign coef_ok  = coef_we && is_idle && ({1'b0, coef_addr} < ORDER_X);

   // A flush in the same cycle as a sample restarts the ring at entry 0.
   assign wr_idx     = hist_clr ? '0 : wr_ptr_q;
   assign wr_ptr_inc = (wr_idx == LAST_K) ? '0 : wr_idx + 1'b1;

   // Tap k reads x[n-k]: (newest - k) mod ORDER.
   assign rd_idx = (newest_q >= k_q) ? (newest_q - k_q)
                                     : (newest_q - k_q + ORDER_LO);

   // ------------------------------------------------------------------------
   // Accumulate and output formatting
   // ------------------------------------------------------------------------
   assign prod_mag = {{(ACC_W-30){1'b0}}, mult_p[29:0]};
   assign prod_s   = mult_p[30] ? (~prod_mag + 1'b1) : prod_mag;
   assign acc_sum  = acc_q + prod_s;

   // |acc| >> 15 computed directly on the upper bits. For a negative value,
   // ~hi equals -hi-1, which is already the truncated magnitude unless the
   // dropped low bits are all zero, in which case one more is needed.
   always_comb begin
      abs_hi = acc_sum[ACC_W-1:15];
      if (acc_sum[ACC_W-1]) begin
         abs_hi = ~acc_sum[ACC_W-1:15] + ((acc_sum[14:0] == 15'd0) ? 1'b1 : 1'b0);
      end
   end

   assign sat     = |abs_hi[ACC_W-16:15];
   assign res_mag = sat ? 15'h7FFF : abs_hi[14:0];
   assign res_neg = acc_sum[ACC_W-1] && (res_mag != 15'd0);

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_slow) begin : p_state_reg
      if (!rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next state
   // ------------------------------------------------------------------------
   always_comb begin : p_next_state
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (in_valid)  state_d = ST_MAC;
         ST_MAC:  if (last_tap)  state_d = ST_OUT;
         ST_OUT:  if (out_ready) state_d = ST_IDLE;
         default:                state_d = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // FSM: outputs
   // ------------------------------------------------------------------------
   always_comb begin : p_outputs
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      mult_a    = 16'h0000;
      mult_b    = 16'h0000;
      case (state_q)
         ST_IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
         end
         ST_MAC: begin
            mult_a = coef_q[k_q];
            mult_b = hist_q[rd_idx];
         end
         ST_OUT: begin
            out_valid = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_slow) begin : p_data
      if (!rst) begin
         for (int i = 0; i < ORDER; i++) begin
            coef_q[i] <= '0;
            hist_q[i] <= '0;
         end
         wr_ptr_q   <= '0;
         newest_q   <= '0;
         k_q        <= '0;
         acc_q      <= '0;
         fir_out_q  <= '0;
         coef_err_q <= 1'b0;
      end else begin
         coef_err_q <= coef_we && !coef_ok;

         if (coef_ok) begin
            coef_q[coef_addr] <= coef_data;
         end

         if (hist_clr) begin
            for (int i = 0; i < ORDER; i++) begin
               hist_q[i] <= '0;
            end
         end

         // Sample store comes after the clear so a simultaneous flush
         // still keeps the new sample at entry 0.
         if (accept) begin
            hist_q[wr_idx] <= fir_in;
            newest_q       <= wr_idx;
            wr_ptr_q       <= wr_ptr_inc;
            acc_q          <= '0;
            k_q            <= '0;
         end else if (hist_clr) begin
            wr_ptr_q <= '0;
         end

         if (is_mac) begin
            acc_q <= acc_sum;
            if (last_tap) begin
               fir_out_q <= {res_neg, res_mag};
            end else begin
               k_q <= k_q + 1'b1;
            end
         end
      end
   end

   assign fir_out  = fir_out_q;
   assign coef_err = coef_err_q;

endmodule

// File: tb/tb_fir_tdm_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fir_tdm_sequencer
//
// Directed bench for fir_tdm_sequencer with a behavioural model of the shared
// sign-magnitude multiplier. A vector table covers the basic filter response;
// hand-written sequences cover backpressure, rejected coefficient writes,
// saturation, simultaneous flush/write with a sample, and mid-run reset.
// ---------------------------------------------------------------------------
module tb_fir_tdm_sequencer;

   localparam int ORDER = 30;
   localparam int AW    = 6;
   localparam int ACC_W = 36;

   localparam int OP_COEF  = 0;
   localparam int OP_SAMP  = 1;
   localparam int OP_FLUSH = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [15:0]   fir_in;
   logic          out_valid;
   logic          out_ready;
   logic [15:0]   fir_out;
   logic          coef_we;
   logic [AW-1:0] coef_addr;
   logic [15:0]   coef_data;
   logic          coef_err;
   logic          flush;
   logic [15:0]   mult_a;
   logic [15:0]   mult_b;
   logic [30:0]   mult_p;
   logic          busy;
   logic [29:0]   prod_mag;

   always #5 clk = ~clk;

   fir_tdm_sequencer #(.ORDER(ORDER), .AW(AW), .ACC_W(ACC_W)) dut (
      .clk_slow  (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .fir_in    (fir_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .fir_out   (fir_out),
      .coef_we   (coef_we),
      .coef_addr (coef_addr),
      .coef_data (coef_data),
      .coef_err  (coef_err),
      .flush     (flush),
      .mult_a    (mult_a),
      .mult_b    (mult_b),
      .mult_p    (mult_p),
      .busy      (busy)
   );

   // Shared multiplier model: sign is XOR of signs, magnitude 15x15.
   assign prod_mag = {15'd0, mult_a[14:0]} * {15'd0, mult_b[14:0]};
   assign mult_p   = {mult_a[15] ^ mult_b[15], prod_mag};

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int acc_cyc;
   int nzb;
   logic [15:0] a0;
   logic [15:0] b0;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          op;
      logic [5:0]  addr;
      logic [15:0] data;
      logic [15:0] exp;   // expected fir_out, or expected coef_err for writes
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic accept(input string nm, input logic [15:0] x);
      chk({nm, "_in_ready"}, in_ready, 1);
      in_valid = 1'b1;
      fir_in   = x;
      tick();
      in_valid = 1'b0;
      acc_cyc  = cyc;
   endtask

   task automatic wait_out(input string nm, input logic [15:0] exp);
      int n;
      n   = 0;
      nzb = 0;
      a0  = '0;
      b0  = '0;
      while (!out_valid && n < 200) begin
         if (n == 0) begin
            a0 = mult_a;
            b0 = mult_b;
         end
         if (mult_b != 16'h0000) nzb++;
         tick();
         n++;
      end
      chk({nm, "_valid"}, out_valid, 1);
      chk({nm, "_latency"}, cyc - acc_cyc + 1, ORDER + 1);
      chk({nm, "_fir_out"}, fir_out, exp);
      chk({nm, "_rdy_busy"}, {in_ready, busy}, 2'b01);
      chk({nm, "_ops_zero"}, {mult_a, mult_b}, 32'h0);
      $display("xfer %s: fir_out=%h expected=%h latency=%0d", nm, fir_out, exp,
               cyc - acc_cyc + 1);
   endtask

   task automatic release_out(input string nm);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({nm, "_released"}, {out_valid, in_ready}, 2'b01);
   endtask

   task automatic sample(input string nm, input logic [15:0] x, input logic [15:0] exp);
      accept(nm, x);
      wait_out(nm, exp);
      release_out(nm);
   endtask

   task automatic coef_wr(input string nm, input logic [AW-1:0] a, input logic [15:0] d,
                          input logic exp_err);
      coef_we   = 1'b1;
      coef_addr = a;
      coef_data = d;
      tick();
      coef_we   = 1'b0;
      chk({nm, "_coef_err"}, coef_err, exp_err);
      if (exp_err) begin
         tick();
         chk({nm, "_coef_err_end"}, coef_err, 0);
      end
      $display("coef %s: addr=%0d data=%h coef_err=%b", nm, a, d, exp_err);
   endtask

   task automatic do_flush();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      $display("flush issued");
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int ov;

      vecs[0] = '{OP_COEF,  6'd0, 16'h0040, 16'h0000};
      vecs[1] = '{OP_COEF,  6'd1, 16'h8040, 16'h0000};
      vecs[2] = '{OP_SAMP,  6'd0, 16'h4000, 16'h0020};
      vecs[3] = '{OP_SAMP,  6'd0, 16'h0000, 16'h8020};
      vecs[4] = '{OP_SAMP,  6'd0, 16'h0000, 16'h0000};
      vecs[5] = '{OP_FLUSH, 6'd0, 16'h0000, 16'h0000};
      vecs[6] = '{OP_COEF,  6'd1, 16'h0000, 16'h0000};
      vecs[7] = '{OP_SAMP,  6'd0, 16'h8000, 16'h0000};
      vecs[8] = '{OP_SAMP,  6'd0, 16'hC000, 16'h8020};

      rst       = 1'b0;
      in_valid  = 1'b0;
      fir_in    = '0;
      out_ready = 1'b0;
      coef_we   = 1'b0;
      coef_addr = '0;
      coef_data = '0;
      flush     = 1'b0;
      repeat (3) tick();
      rst = 1'b1;
      tick();
      chk("reset_flags", {in_ready, out_valid, coef_err, busy}, 4'b1000);
      chk("reset_fir_out", fir_out, 16'h0000);
      chk("reset_ops", {mult_a, mult_b}, 32'h0);

      // Basic response, negative zero and negative input.
      for (int i = 0; i < 9; i++) begin
         case (vecs[i].op)
            OP_COEF:  coef_wr($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data,
                              vecs[i].exp[0]);
            OP_SAMP:  sample($sformatf("vec%0d", i), vecs[i].data, vecs[i].exp);
            default:  do_flush();
         endcase
      end

      // Coefficient write during MAC is rejected; old coefficient is used.
      accept("mac_wr", 16'h4000);
      coef_we   = 1'b1;
      coef_addr = 6'd0;
      coef_data = 16'h7FFF;
      tick();
      coef_we = 1'b0;
      chk("mac_wr_coef_err", coef_err, 1);
      tick();
      chk("mac_wr_coef_err_end", coef_err, 0);
      wait_out("mac_wr", 16'h0020);
      release_out("mac_wr");
      coef_wr("addr31", 6'd31, 16'h7FFF, 1'b1);
      sample("after_bad_wr", 16'h4000, 16'h0020);

      // Backpressure: hold OUT for 5 cycles, an in_valid pulse must be ignored.
      accept("bp", 16'h4000);
      wait_out("bp", 16'h0020);
      ov = 0;
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin
            in_valid = 1'b1;
            fir_in   = 16'h7FFF;
         end
         tick();
         in_valid = 1'b0;
         if (!(out_valid && !in_ready && busy && fir_out == 16'h0020)) ov++;
      end
      chk("bp_hold_stable", ov, 0);
      release_out("bp");
      chk("bp_no_accept", {busy, in_ready}, 2'b01);
      $display("xfer bp_hold: held 5 cycles, unstable_cycles=%0d", ov);

      // Full-scale and saturation.
      do_flush();
      for (int a = 0; a < ORDER; a++) begin
         coef_wr($sformatf("full%0d", a), AW'(a), 16'h7FFF, 1'b0);
      end
      sample("full_1", 16'h7FFF, 16'h7FFE);
      sample("full_2", 16'h7FFF, 16'h7FFF);
      flush = 1'b1;
      accept("flush_in", 16'hFFFF);
      flush = 1'b0;
      wait_out("flush_in", 16'hFFFE);
      release_out("flush_in");
      sample("neg_sat", 16'hFFFF, 16'hFFFF);

      // Reset in the middle of a MAC run.
      accept("rst_mid", 16'h4000);
      repeat (10) tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      chk("rst_mid_flags", {out_valid, busy, in_ready, coef_err}, 4'b0010);
      chk("rst_mid_fir_out", fir_out, 16'h0000);
      chk("rst_mid_ops", {mult_a, mult_b}, 32'h0);
      ov = 0;
      repeat (40) begin
         tick();
         if (out_valid) ov++;
      end
      chk("rst_mid_no_stale", ov, 0);
      coef_wr("rst_c0", 6'd0, 16'h0040, 1'b0);
      accept("rst_new", 16'h4000);
      wait_out("rst_new", 16'h0020);
      chk("rst_new_hist_nonzero", nzb, 1);
      chk("rst_new_first_ops", {a0, b0}, {16'h0040, 16'h4000});
      release_out("rst_new");

      // Coefficient write together with a sample: new value is used.
      coef_we   = 1'b1;
      coef_addr = 6'd0;
      coef_data = 16'h0080;
      accept("we_in", 16'h4000);
      coef_we = 1'b0;
      chk("we_in_coef_err", coef_err, 0);
      wait_out("we_in", 16'h0040);
      release_out("we_in");

      // Flush together with a sample: history cleared, sample lands at 0.
      coef_wr("c1", 6'd1, 16'h0040, 1'b0);
      flush = 1'b1;
      accept("flush_pair", 16'h2000);
      flush = 1'b0;
      wait_out("flush_pair", 16'h0020);
      release_out("flush_pair");
      sample("after_flush", 16'h0000, 16'h0010);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
